// File: rtl/vga_scan_gen_if.sv
// Scan-position bus from the VGA raster generator to the drawing logic.
interface vga_scan_gen_if;
   logic       pix_en;
   logic [9:0] Q_X;
   logic [9:0] Q_Y;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       line_end;
   logic       frame_end;

   modport master (
      output pix_en, Q_X, Q_Y, hsync, vsync, video_on, line_end, frame_end
   );

   modport slave (
      input  pix_en, Q_X, Q_Y, hsync, vsync, video_on, line_end, frame_end
   );
endinterface

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel clock divider, h/v position counters and
// the sync / visible / line / frame decodes every drawing block keys off.
module vga_scan_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          SYNC_POL  = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   vga_scan_gen_if.master scan
);

   localparam int unsigned CNT_W    = 10;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_VISIBLE + H_FP;
   localparam int unsigned HS_END   = H_VISIBLE + H_FP + H_SYNC - 1;
   localparam int unsigned VS_START = V_VISIBLE + V_FP;
   localparam int unsigned VS_END   = V_VISIBLE + V_FP + V_SYNC - 1;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic             div_last_c;
   logic             pix_en_c;
   logic             line_end_c;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;

   // Pixel-rate divider; with CLK_DIV=1 every clk is a pixel period.
   if (CLK_DIV > 1) begin : g_div
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
      logic [DIV_W-1:0] div_cnt;

      always_ff @(posedge clk) begin
         if (rst) begin
            div_cnt <= '0;
         end else if (div_cnt >= DIV_LAST) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end

      assign div_last_c = (div_cnt == DIV_LAST);
   end else begin : g_nodiv
      assign div_last_c = 1'b1;
   end

   // Strobes are suppressed while rst is high so a reset never emits one.
   assign pix_en_c   = ~rst & div_last_c;
   assign line_end_c = pix_en_c & (h_cnt == H_LAST);

   // Position counters; out-of-range values (SEU) fold back to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en_c) begin
         if (h_cnt >= H_LAST) begin
            h_cnt <= '0;
            if (v_cnt >= V_LAST) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + CNT_W'(1);
            end
         end else begin
            h_cnt <= h_cnt + CNT_W'(1);
         end
      end
   end

   // Decodes share the same counter registers, so they move with no skew.
   assign scan.pix_en    = pix_en_c;
   assign scan.Q_X       = h_cnt;
   assign scan.Q_Y       = v_cnt;
   assign scan.line_end  = line_end_c;
   assign scan.frame_end = line_end_c & (v_cnt == V_LAST);
   assign scan.video_on  = (h_cnt < CNT_W'(H_VISIBLE)) & (v_cnt < CNT_W'(V_VISIBLE));
   assign scan.hsync     = ((h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END)))
                           ? SYNC_POL : ~SYNC_POL;
   assign scan.vsync     = ((v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END)))
                           ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: three builds (default VGA, small
// divided-by-3 active-high, small CLK_DIV=1) against an elapsed-time model.
module tb_vga_scan_gen;

   typedef struct {
      int d, hv, hfp, hs, hbp, vv, vfp, vs, vbp;
      bit pol;
   } cfg_t;

   typedef struct {
      bit valid;
      int t;
      int x, y;
      bit pe, le, fe, hs, vs, vo;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t_run  = 0;
   bit t_valid = 1'b0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int last_fe [3] = '{-1, -1, -1};
   int fe_cnt  [3] = '{0, 0, 0};
   int le_cnt  [3] = '{0, 0, 0};

   vga_scan_gen_if if0 ();
   vga_scan_gen_if if1 ();
   vga_scan_gen_if if2 ();

   always #5 clk = ~clk;

   vga_scan_gen dut0 (
      .clk  (clk),
      .rst  (rst),
      .scan (if0)
   );

   vga_scan_gen #(
      .CLK_DIV(3), .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
   ) dut1 (
      .clk  (clk),
      .rst  (rst),
      .scan (if1)
   );

   vga_scan_gen #(
      .CLK_DIV(1), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
   ) dut2 (
      .clk  (clk),
      .rst  (rst),
      .scan (if2)
   );

   function automatic cfg_t get_cfg(input int i);
      cfg_t c;
      case (i)
         0:       c = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
         1:       c = '{3, 20, 3, 5, 4, 10, 2, 2, 3, 1'b1};
         default: c = '{1, 16, 2, 4, 3, 8, 1, 2, 2, 1'b0};
      endcase
      return c;
   endfunction

   function automatic int frame_clks(input int i);
      cfg_t c = get_cfg(i);
      return (c.hv + c.hfp + c.hs + c.hbp) * (c.vv + c.vfp + c.vs + c.vbp) * c.d;
   endfunction

   // Expected outputs after t clks of free running since the last reset edge.
   function automatic exp_t model(input int i, input int t, input bit r);
      cfg_t c = get_cfg(i);
      exp_t e;
      int ht = c.hv + c.hfp + c.hs + c.hbp;
      int vt = c.vv + c.vfp + c.vs + c.vbp;
      int p  = t / c.d;
      e.valid = 1'b1;
      e.t  = t;
      e.x  = p % ht;
      e.y  = (p / ht) % vt;
      e.pe = !r && ((t % c.d) == c.d - 1);
      e.le = e.pe && (e.x == ht - 1);
      e.fe = e.le && (e.y == vt - 1);
      e.hs = (e.x >= c.hv + c.hfp && e.x < c.hv + c.hfp + c.hs) ? c.pol : !c.pol;
      e.vs = (e.y >= c.vv + c.vfp && e.y < c.vv + c.vfp + c.vs) ? c.pol : !c.pol;
      e.vo = (e.x < c.hv) && (e.y < c.vv);
      return e;
   endfunction

   task automatic chk(input string nm, input int i, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, i, cyc, act, want);
      end
   endtask

   // One clk of stimulus: account for the edge just taken, queue expectations, set rst.
   task automatic step(input bit r_next);
      exp_t inv;
      @(posedge clk);
      #1;
      if (rst) begin
         t_run   = 0;
         t_valid = 1'b1;
      end else if (t_valid) begin
         t_run++;
      end
      rst = r_next;
      inv = '{default: 0};
      if (t_valid) begin
         q0.push_back(model(0, t_run, r_next));
         q1.push_back(model(1, t_run, r_next));
         q2.push_back(model(2, t_run, r_next));
      end else begin
         q0.push_back(inv);
         q1.push_back(inv);
         q2.push_back(inv);
      end
   endtask

   task automatic check_dut(input int i, input exp_t e, input int x, input int y,
                            input bit pe, input bit le, input bit fe,
                            input bit hs, input bit vs, input bit vo);
      if (!e.valid) return;
      chk("Q_X", i, x, e.x);
      chk("Q_Y", i, y, e.y);
      chk("pix_en", i, int'(pe), int'(e.pe));
      chk("line_end", i, int'(le), int'(e.le));
      chk("frame_end", i, int'(fe), int'(e.fe));
      chk("hsync", i, int'(hs), int'(e.hs));
      chk("vsync", i, int'(vs), int'(e.vs));
      chk("video_on", i, int'(vo), int'(e.vo));
      if (e.t == 0) last_fe[i] = -1;
      if (le) le_cnt[i]++;
      if (fe) begin
         if (last_fe[i] >= 0) chk("frame_period", i, cyc - last_fe[i], frame_clks(i));
         last_fe[i] = cyc;
         fe_cnt[i]++;
      end
   endtask

   // Monitor: pops one expectation per DUT per clk, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         check_dut(0, e, int'(if0.Q_X), int'(if0.Q_Y), if0.pix_en, if0.line_end,
                   if0.frame_end, if0.hsync, if0.vsync, if0.video_on);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check_dut(1, e, int'(if1.Q_X), int'(if1.Q_Y), if1.pix_en, if1.line_end,
                   if1.frame_end, if1.hsync, if1.vsync, if1.video_on);
      end
      if (q2.size() > 0) begin
         e = q2.pop_front();
         check_dut(2, e, int'(if2.Q_X), int'(if2.Q_Y), if2.pix_en, if2.line_end,
                   if2.frame_end, if2.hsync, if2.vsync, if2.video_on);
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      step(1'b1);
      step(1'b1);
      // Long first run: several VGA lines and many small-build frames.
      for (int k = 0; k < 6000; k++) step(1'b0);
      // Randomized mid-frame resets of random length and random run lengths.
      for (int j = 0; j < 15; j++) begin
         n = $urandom_range(4, 1);
         for (int k = 0; k < n; k++) step(1'b1);
         n = $urandom_range(3000, 20);
         for (int k = 0; k < n; k++) step(1'b0);
      end
      @(negedge clk);
      #1;
      chk("line_end_seen", 0, int'(le_cnt[0] >= 3), 1);
      chk("frame_end_seen", 1, int'(fe_cnt[1] >= 2), 1);
      chk("frame_end_seen", 2, int'(fe_cnt[2] >= 2), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
